// File: rtl/sssp_scatter_lanes.sv
// sssp_scatter_lanes: multi-lane SSSP scatter stage for one vertex partition.
//   Inputs : clk, rst (async, active-low), control (0 idle, 1 load, 2 scatter,
//            3 idle), current_level, word_in (vertex or edge line), w_addr,
//            word_in_valid, lane_mask, last_input_in.
//   Outputs: word_out/valid_out (per-lane {dst, weight} updates), sideband
//            copies delayed 4 cycles, update/drop counters, done pulse.
//   Optional: define SSSP_WEIGHT_SAT_EN to clamp summed weights at 0xFFFFFFFF.
module sssp_scatter_lanes #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LANES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            control,
    input  logic [15:0]           current_level,
    input  logic [511:0]          word_in,
    input  logic [31:0]           w_addr,
    input  logic                  word_in_valid,
    input  logic [LANES-1:0]      lane_mask,
    input  logic                  last_input_in,
    output logic [LANES*64-1:0]   word_out,
    output logic [LANES-1:0]      valid_out,
    output logic                  word_in_valid_out,
    output logic                  last_input_out,
    output logic [1:0]            control_out,
    output logic [31:0]           update_count,
    output logic [31:0]           drop_count,
    output logic                  done
);

    localparam int unsigned LINE_W    = 512;
    localparam int unsigned EDGE_W    = 128;
    localparam int unsigned EDGE_USED = 96;
    localparam int unsigned UPD_W     = 64;
    localparam int unsigned LINE_AW   = ADDR_W - 3;
    localparam int unsigned LINES     = 1 << LINE_AW;
    localparam int unsigned PFX_W     = 32 - ADDR_W;
    localparam logic [1:0]  CTRL_LOAD = 2'd1;
    localparam logic [1:0]  CTRL_SCAT = 2'd2;

    typedef struct packed {
        logic [31:0] wt;
        logic [31:0] dst;
        logic [31:0] src;
    } edge_t;

    // Vertex RAM, one replicated copy per lane; not reset.
    logic [LINE_W-1:0] vram [LANES][LINES];

    // Stage 1: captured edge line and sideband.
    logic s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [1:0] s1_ctrl_q, s1_ctrl_d;
    logic [LANES-1:0] s1_upd_q, s1_upd_d;
    logic [15:0] s1_lvl_q, s1_lvl_d;
    edge_t s1_edge_q [LANES];
    edge_t s1_edge_d [LANES];
    // Stage 2: RAM read data plus the edge fields still needed.
    logic s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
    logic [1:0] s2_ctrl_q, s2_ctrl_d;
    logic [LANES-1:0] s2_upd_q, s2_upd_d;
    logic [15:0] s2_lvl_q, s2_lvl_d;
    logic [PFX_W-1:0] s2_pfx_q [LANES];
    logic [PFX_W-1:0] s2_pfx_d [LANES];
    logic [31:0] s2_dst_q [LANES];
    logic [31:0] s2_dst_d [LANES];
    logic [31:0] s2_ewt_q [LANES];
    logic [31:0] s2_ewt_d [LANES];
    logic [31:0] rd_wt_q [LANES];
    logic [31:0] rd_wt_d [LANES];
    logic [15:0] rd_lvl_q [LANES];
    logic [15:0] rd_lvl_d [LANES];
    // Stage 3: match flags and sum.
    logic s3_vld_q, s3_vld_d, s3_last_q, s3_last_d;
    logic [1:0] s3_ctrl_q, s3_ctrl_d;
    logic [LANES-1:0] s3_upd_q, s3_upd_d, s3_pm_q, s3_pm_d, s3_lm_q, s3_lm_d;
    logic [31:0] s3_dst_q [LANES];
    logic [31:0] s3_dst_d [LANES];
    logic [31:0] s3_sum_q [LANES];
    logic [31:0] s3_sum_d [LANES];
    // Output stage and pass state.
    logic [LANES*UPD_W-1:0] word_out_q, word_out_d;
    logic [LANES-1:0] valid_out_q, valid_out_d;
    logic vld_out_q, vld_out_d, last_out_q, last_out_d, done_q, done_d;
    logic [1:0] ctrl_out_q, ctrl_out_d, ctrl_prev_q, ctrl_prev_d;
    logic [31:0] upd_cnt_q, upd_cnt_d, drop_cnt_q, drop_cnt_d;
    logic [PFX_W-1:0] prefix_q, prefix_d;
    logic [LANES-1:0] emit_c, drop_c;
`ifdef SSSP_WEIGHT_SAT_EN
    logic [32:0] sum_wide;
`endif

    // Line offset bits of w_addr are implied by 8-vertex alignment.
    logic unused_waddr_lo;
    assign unused_waddr_lo = ^w_addr[2:0];

    function automatic logic [31:0] popcnt(input logic [LANES-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int unsigned k = 0; k < LANES; k++) n = n + 32'(v[k]);
        return n;
    endfunction

    // Vertex load: every lane copy receives the same line.
    always_ff @(posedge clk) begin
        if (control == CTRL_LOAD && word_in_valid) begin
            for (int unsigned i = 0; i < LANES; i++)
                vram[i][w_addr[ADDR_W-1:3]] <= word_in;
        end
    end

    // Next-state for the pipeline, counters and prefix.
    always_comb begin
        s1_vld_d  = word_in_valid;
        s1_last_d = last_input_in;
        s1_ctrl_d = control;
        s1_lvl_d  = current_level;
        s1_upd_d  = (word_in_valid && control == CTRL_SCAT) ? lane_mask : '0;
        s2_vld_d  = s1_vld_q;
        s2_last_d = s1_last_q;
        s2_ctrl_d = s1_ctrl_q;
        s2_upd_d  = s1_upd_q;
        s2_lvl_d  = s1_lvl_q;
        s3_vld_d  = s2_vld_q;
        s3_last_d = s2_last_q;
        s3_ctrl_d = s2_ctrl_q;
        s3_upd_d  = s2_upd_q;
        s3_pm_d   = '0;
        s3_lm_d   = '0;
`ifdef SSSP_WEIGHT_SAT_EN
        sum_wide  = '0;
`endif
        for (int unsigned i = 0; i < LANES; i++) begin
            s1_edge_d[i] = word_in[i*EDGE_W +: EDGE_USED];
            // Slot k occupies bits k*64+63:k*64; weight at +32, level at +0.
            rd_wt_d[i]  = vram[i][s1_edge_q[i].src[ADDR_W-1:3]][{s1_edge_q[i].src[2:0], 6'd32} +: 32];
            rd_lvl_d[i] = vram[i][s1_edge_q[i].src[ADDR_W-1:3]][{s1_edge_q[i].src[2:0], 6'd0} +: 16];
            s2_pfx_d[i] = s1_edge_q[i].src[31:ADDR_W];
            s2_dst_d[i] = s1_edge_q[i].dst;
            s2_ewt_d[i] = s1_edge_q[i].wt;
            s3_pm_d[i]  = (s2_pfx_q[i] == prefix_q);
            s3_lm_d[i]  = (rd_lvl_q[i] == s2_lvl_q);
            s3_dst_d[i] = s2_dst_q[i];
`ifdef SSSP_WEIGHT_SAT_EN
            sum_wide    = 33'(rd_wt_q[i]) + 33'(s2_ewt_q[i]);
            s3_sum_d[i] = sum_wide[32] ? 32'hFFFF_FFFF : sum_wide[31:0];
`else
            s3_sum_d[i] = rd_wt_q[i] + s2_ewt_q[i];
`endif
        end

        emit_c      = s3_upd_q & s3_pm_q & s3_lm_q;
        drop_c      = s3_upd_q & ~(s3_pm_q & s3_lm_q);
        valid_out_d = emit_c;
        word_out_d  = '0;
        for (int unsigned i = 0; i < LANES; i++)
            if (emit_c[i]) word_out_d[i*UPD_W +: UPD_W] = {s3_dst_q[i], s3_sum_q[i]};
        vld_out_d   = s3_vld_q;
        last_out_d  = s3_last_q;
        ctrl_out_d  = s3_ctrl_q;
        done_d      = last_out_q && ctrl_out_q == CTRL_SCAT;

        // Counters restart when a scatter pass begins.
        ctrl_prev_d = control;
        if (control == CTRL_SCAT && ctrl_prev_q != CTRL_SCAT) begin
            upd_cnt_d  = popcnt(emit_c);
            drop_cnt_d = popcnt(drop_c);
        end else begin
            upd_cnt_d  = upd_cnt_q + popcnt(emit_c);
            drop_cnt_d = drop_cnt_q + popcnt(drop_c);
        end

        prefix_d = prefix_q;
        if (control == CTRL_LOAD && word_in_valid) prefix_d = w_addr[31:ADDR_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q <= 1'b0; s1_last_q <= 1'b0; s1_ctrl_q <= '0; s1_upd_q <= '0; s1_lvl_q <= '0;
            s2_vld_q <= 1'b0; s2_last_q <= 1'b0; s2_ctrl_q <= '0; s2_upd_q <= '0; s2_lvl_q <= '0;
            s3_vld_q <= 1'b0; s3_last_q <= 1'b0; s3_ctrl_q <= '0; s3_upd_q <= '0;
            s3_pm_q <= '0; s3_lm_q <= '0;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_edge_q[i] <= '0; s2_pfx_q[i] <= '0; s2_dst_q[i] <= '0; s2_ewt_q[i] <= '0;
                rd_wt_q[i] <= '0; rd_lvl_q[i] <= '0; s3_dst_q[i] <= '0; s3_sum_q[i] <= '0;
            end
            word_out_q <= '0; valid_out_q <= '0; vld_out_q <= 1'b0; last_out_q <= 1'b0;
            ctrl_out_q <= '0; ctrl_prev_q <= '0; upd_cnt_q <= '0; drop_cnt_q <= '0;
            done_q <= 1'b0; prefix_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d; s1_last_q <= s1_last_d; s1_ctrl_q <= s1_ctrl_d;
            s1_upd_q <= s1_upd_d; s1_lvl_q <= s1_lvl_d;
            s2_vld_q <= s2_vld_d; s2_last_q <= s2_last_d; s2_ctrl_q <= s2_ctrl_d;
            s2_upd_q <= s2_upd_d; s2_lvl_q <= s2_lvl_d;
            s3_vld_q <= s3_vld_d; s3_last_q <= s3_last_d; s3_ctrl_q <= s3_ctrl_d;
            s3_upd_q <= s3_upd_d; s3_pm_q <= s3_pm_d; s3_lm_q <= s3_lm_d;
            for (int unsigned i = 0; i < LANES; i++) begin
                s1_edge_q[i] <= s1_edge_d[i]; s2_pfx_q[i] <= s2_pfx_d[i];
                s2_dst_q[i] <= s2_dst_d[i]; s2_ewt_q[i] <= s2_ewt_d[i];
                rd_wt_q[i] <= rd_wt_d[i]; rd_lvl_q[i] <= rd_lvl_d[i];
                s3_dst_q[i] <= s3_dst_d[i]; s3_sum_q[i] <= s3_sum_d[i];
            end
            word_out_q <= word_out_d; valid_out_q <= valid_out_d; vld_out_q <= vld_out_d;
            last_out_q <= last_out_d; ctrl_out_q <= ctrl_out_d; ctrl_prev_q <= ctrl_prev_d;
            upd_cnt_q <= upd_cnt_d; drop_cnt_q <= drop_cnt_d; done_q <= done_d;
            prefix_q <= prefix_d;
        end
    end

    assign word_out          = word_out_q;
    assign valid_out         = valid_out_q;
    assign word_in_valid_out = vld_out_q;
    assign last_input_out    = last_out_q;
    assign control_out       = ctrl_out_q;
    assign update_count      = upd_cnt_q;
    assign drop_count        = drop_cnt_q;
    assign done              = done_q;

endmodule
